// File: rtl/seg_disp_arbiter.sv
// rtl/seg_disp_arbiter.sv - round-robin owner of the shared 4-digit 7-segment display
// Ports: clk, rst (synchronous, active high); req[NUM_REQ] level requests;
//   value[NUM_REQ*14] packed binary values, requester i at [14*i+13:14*i];
//   gnt one-hot current owner (zero when none); busy during BCD conversion;
//   anode[3:0] active-low digit enables; seg[6:0] active-low segments g..a.
// Optional: define SEG_LZ_BLANK_EN to store leading zero digits as blank.
module seg_disp_arbiter #(
    parameter int NUM_REQ     = 2,
    parameter int SCAN_DIV    = 100000,
    parameter int HOLD_FRAMES = 250
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ*14-1:0] value,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  busy,
    output logic [3:0]            anode,
    output logic [6:0]            seg
);
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = $clog2(HOLD_FRAMES + 1);
    localparam logic [3:0] BLANK = 4'hF;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CONV, S_DONE} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] scan_cnt;
    logic [1:0]    digit_idx;
    logic          fs;
    logic [FW-1:0] frame_cnt;
    logic          owner_vld;
    logic [1:0]    owner_idx;
    logic [1:0]    rr_ptr;
    logic [15:0]   disp;      // four digit codes, digit 0 (ones) in [3:0]
    logic [13:0]   shreg;
    logic [15:0]   bcd;
    logic [15:0]   bcd_adj;
    logic [15:0]   bcd_step;
    logic [3:0]    bit_cnt;
    logic [3:0]    req_pad;
    logic [55:0]   value_pad;
    logic [13:0]   owner_val;
    logic [13:0]   owner_sat;
    logic [3:0]    cur_digit;

    logic       hold_done, others_req, do_arb, arb_found, owner_chg, owner_vld_nxt;
    logic [1:0] arb_start, arb_pick, owner_nxt, rr_nxt;
    logic [2:0] probe;

    // Pad request/value buses to the 4-requester maximum so owner-indexed
    // selects stay in range for every NUM_REQ.
    always_comb begin
        req_pad                      = '0;
        req_pad[NUM_REQ-1:0]         = req;
        value_pad                    = '0;
        value_pad[NUM_REQ*14-1:0]    = value;
    end

    always_comb begin
        owner_val = value_pad[13:0];
        case (owner_idx)
            2'd1:    owner_val = value_pad[27:14];
            2'd2:    owner_val = value_pad[41:28];
            2'd3:    owner_val = value_pad[55:42];
            default: owner_val = value_pad[13:0];
        endcase
        owner_sat = (owner_val > 14'd9999) ? 14'd9999 : owner_val;
    end

    assign fs = (scan_cnt == '0) && (digit_idx == 2'd0);

    // Arbitration decision, only committed at frame start.
    always_comb begin
        hold_done  = (frame_cnt >= FW'(HOLD_FRAMES - 1));
        others_req = |(req_pad & ~(4'b0001 << owner_idx));
        do_arb     = 1'b0;
        arb_start  = rr_ptr;
        if (!owner_vld || !req_pad[owner_idx]) begin
            do_arb = 1'b1;
        end else if (hold_done && others_req) begin
            do_arb    = 1'b1;
            arb_start = (owner_idx == 2'(NUM_REQ - 1)) ? 2'd0 : owner_idx + 2'd1;
        end
        arb_found = 1'b0;
        arb_pick  = 2'd0;
        probe     = 3'd0;
        for (int k = 0; k < NUM_REQ; k++) begin
            probe = {1'b0, arb_start} + 3'(k);
            if (probe >= 3'(NUM_REQ)) begin
                probe = probe - 3'(NUM_REQ);
            end
            if (!arb_found && req_pad[probe[1:0]]) begin
                arb_found = 1'b1;
                arb_pick  = probe[1:0];
            end
        end
        owner_vld_nxt = do_arb ? arb_found : owner_vld;
        owner_nxt     = (do_arb && arb_found) ? arb_pick : owner_idx;
        owner_chg     = (owner_vld_nxt != owner_vld) ||
                        (owner_vld_nxt && (owner_nxt != owner_idx));
        rr_nxt        = (arb_pick == 2'(NUM_REQ - 1)) ? 2'd0 : arb_pick + 2'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
            frame_cnt <= '0;
            owner_vld <= 1'b0;
            owner_idx <= 2'd0;
            rr_ptr    <= 2'd0;
        end else begin
            if (scan_cnt == CW'(SCAN_DIV - 1)) begin
                scan_cnt  <= '0;
                digit_idx <= digit_idx + 2'd1;
            end else begin
                scan_cnt <= scan_cnt + 1'b1;
            end
            if (fs) begin
                owner_vld <= owner_vld_nxt;
                owner_idx <= owner_nxt;
                if (do_arb && arb_found) begin
                    rr_ptr <= rr_nxt;
                end
                // Saturates once the hold time is reached; only the threshold matters.
                if (owner_chg) begin
                    frame_cnt <= '0;
                end else if (!hold_done) begin
                    frame_cnt <= frame_cnt + 1'b1;
                end
            end
        end
    end

    // Converter FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (fs && owner_vld_nxt) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_CONV;
            S_CONV:  if (bit_cnt == 4'd13) state_nxt = S_DONE;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    function automatic logic [15:0] add3(input logic [15:0] b);
        logic [15:0] r;
        r = b;
        for (int n = 0; n < 4; n++) begin
            if (r[4*n +: 4] >= 4'd5) begin
                r[4*n +: 4] = r[4*n +: 4] + 4'd3;
            end
        end
        return r;
    endfunction

    function automatic logic [15:0] lz_blank(input logic [15:0] d);
        logic [15:0] r;
        r = d;
`ifdef SEG_LZ_BLANK_EN
        if (r[15:12] == 4'd0) begin
            r[15:12] = BLANK;
            if (r[11:8] == 4'd0) begin
                r[11:8] = BLANK;
                if (r[7:4] == 4'd0) begin
                    r[7:4] = BLANK;
                end
            end
        end
`endif
        return r;
    endfunction

    assign bcd_adj  = add3(bcd);
    assign bcd_step = (bcd_adj << 1) | 16'(shreg[13]);

    // The last shift is written straight into disp, so the new digits are
    // visible during DONE, 16 cycles after frame start.
    always_ff @(posedge clk) begin
        if (rst) begin
            disp    <= {4{BLANK}};
            shreg   <= '0;
            bcd     <= '0;
            bit_cnt <= '0;
        end else begin
            if (fs && !owner_vld_nxt) begin
                disp <= {4{BLANK}};
            end
            case (state)
                S_LOAD: begin
                    shreg   <= owner_sat;
                    bcd     <= '0;
                    bit_cnt <= '0;
                end
                S_CONV: begin
                    shreg   <= shreg << 1;
                    bcd     <= bcd_step;
                    bit_cnt <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd13) begin
                        disp <= lz_blank(bcd_step);
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy  = (state == S_LOAD) || (state == S_CONV);
    assign anode = ~(4'b0001 << digit_idx);

    always_comb begin
        gnt = '0;
        if (owner_vld) begin
            gnt = NUM_REQ'(4'b0001 << owner_idx);
        end
    end

    always_comb begin
        cur_digit = disp[{digit_idx, 2'b00} +: 4];
        case (cur_digit)
            4'd0:    seg = 7'b1000000;
            4'd1:    seg = 7'b1111001;
            4'd2:    seg = 7'b0100100;
            4'd3:    seg = 7'b0110000;
            4'd4:    seg = 7'b0011001;
            4'd5:    seg = 7'b0010010;
            4'd6:    seg = 7'b0000010;
            4'd7:    seg = 7'b1011000;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0010000;
            default: seg = 7'b1111111;
        endcase
    end
endmodule

// File: tb/tb_seg_disp_arbiter.sv
// tb/tb_seg_disp_arbiter.sv - self-checking bench for seg_disp_arbiter
module tb_seg_disp_arbiter;
    localparam int NREQ  = 2;
    localparam int SCAN  = 20;
    localparam int HOLD  = 2;
    localparam int FRAME = 4 * SCAN;

    logic        clk;
    logic        rst;
    logic [1:0]  req;
    logic [13:0] v0, v1;
    logic [27:0] value;
    logic [1:0]  gnt;
    logic        busy;
    logic [3:0]  anode;
    logic [6:0]  seg;

    assign value = {v1, v0};

    seg_disp_arbiter #(.NUM_REQ(NREQ), .SCAN_DIV(SCAN), .HOLD_FRAMES(HOLD)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .value (value),
        .gnt   (gnt),
        .busy  (busy),
        .anode (anode),
        .seg   (seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors;
    int checks;
    int frame_no;
    int shown_val;   // value on display at the end of the previous frame, -1 = blank
    int m_owner, m_rr, m_fc;

    typedef struct {
        logic [1:0]  req;
        logic [13:0] v0;
        logic [13:0] v1;
        logic [1:0]  egnt;
        int          eval;
    } vec_t;
    vec_t tbl[13];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s frame=%0d got=%0d expected=%0d", name, frame_no, act, exp);
        end
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1011000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [6:0] exp_seg(input int val, input int pos);
        int p10;
        int dig;
        if (val < 0) return 7'b1111111;
        p10 = 1;
        for (int i = 0; i < pos; i++) p10 = p10 * 10;
        dig = (val / p10) % 10;
`ifdef SEG_LZ_BLANK_EN
        if (pos > 0 && val < p10) return 7'b1111111;
`endif
        return pat(dig);
    endfunction

    // Reference: owner keeps the display while requesting until its hold
    // time is used up and someone else waits; otherwise round-robin search.
    task automatic model_fs(input logic [1:0] r);
        int  start;
        int  pick;
        bit  rearb;
        rearb = 1'b0;
        start = m_rr;
        if (m_owner < 0 || r[m_owner] == 1'b0) begin
            rearb = 1'b1;
        end else if (m_fc >= HOLD - 1 && (r & ~(2'b01 << m_owner)) != 2'b00) begin
            rearb = 1'b1;
            start = (m_owner + 1) % NREQ;
        end
        if (!rearb) begin
            m_fc++;
            return;
        end
        pick = -1;
        for (int k = 0; k < NREQ; k++) begin
            if (pick < 0 && r[(start + k) % NREQ]) pick = (start + k) % NREQ;
        end
        if (pick != m_owner) m_fc = 0;
        else m_fc++;
        if (pick >= 0) m_rr = (pick + 1) % NREQ;
        m_owner = pick;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        tick();
        check("rst_anode", anode, 4'b1110);
        check("rst_seg", seg, 7'b1111111);
        check("rst_gnt", gnt, 2'b00);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        m_owner   = -1;
        m_rr      = 0;
        m_fc      = 0;
        shown_val = -1;
    endtask

    // Starts in a frame-start cycle with inputs already applied; ends in the next one.
    task automatic run_frame(input logic [1:0] egnt, input int eval, input int moff,
                             input logic [1:0] mreq, input logic [13:0] mv0,
                             input logic [13:0] mv1);
        int anode_bad;
        int busy_cnt;
        logic [3:0] ea;
        anode_bad = 0;
        busy_cnt  = 0;
        for (int off = 0; off < FRAME; off++) begin
            ea = 4'b1111;
            ea[off / SCAN] = 1'b0;
            if (anode !== ea) anode_bad++;
            if (busy === 1'b1) busy_cnt++;
            if (off == 1) check("gnt", gnt, egnt);
            if (off == 15) check("seg_d0_prev", seg, (egnt != 2'b00) ? exp_seg(shown_val, 0) : 7'b1111111);
            if (off == 16) check("seg_d0", seg, exp_seg(eval, 0));
            if (off == 30 || off == 50 || off == 70) check("seg_digit", seg, exp_seg(eval, off / SCAN));
            if (off == moff) begin
                req = mreq;
                v0  = mv0;
                v1  = mv1;
            end
            tick();
        end
        check("anode_scan", anode_bad, 0);
        check("busy_cycles", busy_cnt, (egnt != 2'b00) ? 15 : 0);
        shown_val = eval;
        frame_no++;
    endtask

    initial begin
        logic [1:0]  r;
        logic [1:0]  eg;
        int          ev;
        int          vs;
        errors   = 0;
        checks   = 0;
        frame_no = 0;
        rst = 1'b1;
        req = 2'b00;
        v0  = '0;
        v1  = '0;

        tbl[0]  = '{2'b00, 14'd0,     14'd0,    2'b00, -1};
        tbl[1]  = '{2'b01, 14'd1234,  14'd0,    2'b01, 1234};
        tbl[2]  = '{2'b01, 14'd16383, 14'd0,    2'b01, 9999};
        tbl[3]  = '{2'b11, 14'd5,     14'd9876, 2'b10, 9876};
        tbl[4]  = '{2'b11, 14'd5,     14'd9876, 2'b10, 9876};
        tbl[5]  = '{2'b11, 14'd5,     14'd9876, 2'b01, 5};
        tbl[6]  = '{2'b11, 14'd5,     14'd9876, 2'b01, 5};
        tbl[7]  = '{2'b11, 14'd5,     14'd9876, 2'b10, 9876};
        tbl[8]  = '{2'b01, 14'd0,     14'd9876, 2'b01, 0};
        tbl[9]  = '{2'b00, 14'd0,     14'd9876, 2'b00, -1};
        tbl[10] = '{2'b10, 14'd0,     14'd42,   2'b10, 42};
        tbl[11] = '{2'b11, 14'd7,     14'd42,   2'b10, 42};
        tbl[12] = '{2'b11, 14'd7,     14'd42,   2'b01, 7};

        do_reset();
        for (int i = 0; i < 13; i++) begin
            req = tbl[i].req;
            v0  = tbl[i].v0;
            v1  = tbl[i].v1;
            run_frame(tbl[i].egnt, tbl[i].eval, -1, 2'b00, 14'd0, 14'd0);
        end

        // Value change mid-conversion is ignored until the next frame.
        do_reset();
        req = 2'b01;
        v0  = 14'd77;
        v1  = 14'd0;
        run_frame(2'b01, 77, 6, 2'b01, 14'd88, 14'd0);
        run_frame(2'b01, 88, -1, 2'b00, 14'd0, 14'd0);

        // Owner drops mid-frame: digits hold, then blank at the next frame start.
        run_frame(2'b01, 88, 40, 2'b00, 14'd88, 14'd0);
        run_frame(2'b00, -1, -1, 2'b00, 14'd0, 14'd0);

        // Reset in the middle of a conversion.
        req = 2'b01;
        v0  = 14'd1234;
        run_frame(2'b01, 1234, -1, 2'b00, 14'd0, 14'd0);
        for (int off = 0; off < 8; off++) tick();
        check("busy_mid_conv", busy, 1);
        rst = 1'b1;
        tick();
        check("abort_busy", busy, 0);
        check("abort_gnt", gnt, 2'b00);
        check("abort_anode", anode, 4'b1110);
        check("abort_seg", seg, 7'b1111111);
        do_reset();

        // Randomized frames against the reference model.
        for (int f = 0; f < 30; f++) begin
            r  = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'($urandom_range(0, 3));
            vs = $urandom_range(0, 3);
            v0 = (vs == 0) ? 14'($urandom_range(0, 99)) : 14'($urandom_range(0, 16383));
            v1 = (vs == 1) ? 14'($urandom_range(0, 99)) : 14'($urandom_range(0, 16383));
            req = r;
            model_fs(r);
            if (m_owner < 0) begin
                eg = 2'b00;
                ev = -1;
            end else begin
                eg = 2'(1 << m_owner);
                ev = (m_owner == 0) ? int'(v0) : int'(v1);
                if (ev > 9999) ev = 9999;
            end
            run_frame(eg, ev, $urandom_range(2, 14), r,
                      14'($urandom_range(0, 16383)), 14'($urandom_range(0, 16383)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
